three_phase_pwm_capture: RTL

- Receive-side counterpart of the three-phase PWM generator: measures period and high time of three PWM inputs.
- Used for loop-back self-test of the generator and for capturing external gate-driver/feedback PWM.
- Each channel independently reports per-cycle Period/HighTime with a Valid strobe and stuck-line detection.
- A shared interrupt flag follows the generator's enable/clear style.

---
 rtl/three_phase_pwm_pkg.sv | 13 +
 rtl/pwm_capture_channel.sv | 107 ++++++++++
 rtl/three_phase_pwm_capture.sv | 65 ++++++
 3 files changed

// File: rtl/three_phase_pwm_pkg.sv
// rtl/three_phase_pwm_pkg.sv - shared types and constants for the three-phase PWM capture block
package three_phase_pwm_pkg;

   localparam int NUM_PHASES    = 3;
   localparam int DEFAULT_CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } chan_state_t;

endpackage

// File: rtl/pwm_capture_channel.sv
// rtl/pwm_capture_channel.sv - single-line PWM period/high-time capture with stuck-line detection
module pwm_capture_channel
   import three_phase_pwm_pkg::*;
#(
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   input  logic [CNT_W-1:0] timeout,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   chan_state_t            state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   lvl, rise, fall, timed_out;
   logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc, ht, ht_nxt;
   logic [CNT_W-1:0]       period_nxt, high_time_nxt;
   logic                   valid_nxt, stuck_nxt, stuck_level_nxt;

   assign lvl       = sync[SYNC_STAGES-1];
   assign rise      = lvl & ~prev;
   assign fall      = ~lvl & prev;
   assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   assign timed_out = (timeout != '0) && (cnt >= timeout);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync        <= '0;
         prev        <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         ht          <= '0;
         period      <= '0;
         high_time   <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], pwm_in};
         prev        <= lvl;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         ht          <= ht_nxt;
         period      <= period_nxt;
         high_time   <= high_time_nxt;
         valid       <= valid_nxt;
         stuck       <= stuck_nxt;
         stuck_level <= stuck_level_nxt;
      end
   end

   // A stuck line takes priority over an edge seen in the same cycle.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      ht_nxt          = ht;
      period_nxt      = period;
      high_time_nxt   = high_time;
      valid_nxt       = 1'b0;
      stuck_nxt       = stuck;
      stuck_level_nxt = stuck_level;
      if (!enable) begin
         state_nxt       = IDLE;
         cnt_nxt         = '0;
         stuck_nxt       = 1'b0;
         stuck_level_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nxt = HIGH;
                  cnt_nxt   = CNT_W'(1);
                  stuck_nxt = 1'b0;
               end
            end
            HIGH, LOW: begin
               cnt_nxt = cnt_inc;
               if (timed_out) begin
                  state_nxt       = IDLE;
                  cnt_nxt         = '0;
                  stuck_nxt       = 1'b1;
                  stuck_level_nxt = lvl;
               end else if (state == HIGH && fall) begin
                  ht_nxt    = cnt;
                  state_nxt = LOW;
               end else if (state == LOW && rise) begin
                  period_nxt    = cnt;
                  high_time_nxt = ht;
                  valid_nxt     = 1'b1;
                  cnt_nxt       = CNT_W'(1);
                  state_nxt     = HIGH;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/three_phase_pwm_capture.sv
// rtl/three_phase_pwm_capture.sv - three independent PWM capture channels plus a shared completion interrupt
module three_phase_pwm_capture
   import three_phase_pwm_pkg::*;
#(
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [2:0]       PwmIn,
   input  logic [CNT_W-1:0] Timeout,
   output logic [CNT_W-1:0] Period_0,
   output logic [CNT_W-1:0] Period_1,
   output logic [CNT_W-1:0] Period_2,
   output logic [CNT_W-1:0] HighTime_0,
   output logic [CNT_W-1:0] HighTime_1,
   output logic [CNT_W-1:0] HighTime_2,
   output logic [2:0]       Valid,
   output logic [2:0]       Stuck,
   output logic [2:0]       StuckLevel,
   input  logic             Interrupt_Enable,
   input  logic             Interrupt_Clear,
   output logic             Interrupt_Active
);

   logic [CNT_W-1:0] period    [NUM_PHASES];
   logic [CNT_W-1:0] high_time [NUM_PHASES];

   for (genvar i = 0; i < NUM_PHASES; i++) begin : g_ch
      pwm_capture_channel #(
         .CNT_W      (CNT_W),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
         .clk        (Clk),
         .reset      (Reset),
         .enable     (Enable),
         .pwm_in     (PwmIn[i]),
         .timeout    (Timeout),
         .period     (period[i]),
         .high_time  (high_time[i]),
         .valid      (Valid[i]),
         .stuck      (Stuck[i]),
         .stuck_level(StuckLevel[i])
      );
   end

   assign Period_0   = period[0];
   assign Period_1   = period[1];
   assign Period_2   = period[2];
   assign HighTime_0 = high_time[0];
   assign HighTime_1 = high_time[1];
   assign HighTime_2 = high_time[2];

   // Setting wins over a simultaneous clear so no completion is lost.
   always_ff @(posedge Clk) begin
      if (Reset)
         Interrupt_Active <= 1'b0;
      else if (Interrupt_Enable && (|Valid))
         Interrupt_Active <= 1'b1;
      else if (Interrupt_Clear)
         Interrupt_Active <= 1'b0;
   end

endmodule
